addr_router: RTL and testbench

Downstream companion to the arbiter. Consumes the arbiter's `{address, payload}` stream and steers each payload to the output port named by its address field. The address field is stripped on the way out. A 2-entry input queue decouples `istream_rdy` from every `ostream_rdy`, which breaks the combinational ready path back through the arbiter. Messages whose address is out of range are discarded and counted.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_queue2.sv | 61 ++++++
 rtl/addr_router.sv | 86 ++++++++
 tb/tb_addr_router.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the address router: counter width and address extraction.
package router_pkg;

  // Width of the saturating drop counter.
  localparam int DROP_NBITS = 16;

  // Upper bounds used by route_addr so it can serve any instance width.
  localparam int MSG_MAX_NBITS  = 64;
  localparam int ADDR_MAX_NBITS = 8;

  // Returns the address field, which occupies the top addr_nbits of a
  // msg_nbits-wide message (message zero-extended into MSG_MAX_NBITS).
  function automatic logic [ADDR_MAX_NBITS-1:0] route_addr(
    input logic [MSG_MAX_NBITS-1:0] msg,
    input int                       msg_nbits,
    input int                       addr_nbits
  );
    logic [ADDR_MAX_NBITS-1:0] w_mask;
    w_mask = (ADDR_MAX_NBITS'(1) << addr_nbits) - ADDR_MAX_NBITS'(1);
    return ADDR_MAX_NBITS'(msg >> (msg_nbits - addr_nbits)) & w_mask;
  endfunction

endpackage

// File: rtl/router_queue2.sv
// Two-entry circular FIFO. Full/empty come straight from the registered
// occupancy, so nothing upstream sees a combinational path from downstream.
module router_queue2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enq,
  input  logic             i_deq,
  input  logic [width-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [width-1:0] o_head
);

  logic [width-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_full   = (r_count == 2'd2);
  assign o_empty  = (r_count == 2'd0);
  assign o_head   = r_mem[r_rd_ptr];

  // A dequeue on an empty queue has no head to remove, so both requests are
  // qualified here; enqueue-into-empty therefore only grows the queue.
  assign w_do_enq = i_enq & ~o_full;
  assign w_do_deq = i_deq & ~o_empty;

  // Pointer and occupancy bookkeeping.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_enq) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_deq) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; written at the write pointer on every accepted enqueue.
  // NOTE: only two entries, so they are reset to give a defined head (zero) while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (w_do_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/addr_router.sv
// Address router: queues {addr, payload} words, steers each payload to the
// port named by its address, and discards and counts out-of-range addresses.
module addr_router
  import router_pkg::*;
#(
  parameter  int nbits      = 32,
  parameter  int noutputs   = 3,
  localparam int addr_nbits = $clog2(noutputs)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        istream_val,
  output logic                        istream_rdy,
  input  logic [addr_nbits+nbits-1:0] istream_msg,
  output logic [noutputs-1:0]         ostream_val,
  input  logic [noutputs-1:0]         ostream_rdy,
  output logic [nbits-1:0]            ostream_msg [noutputs],
  output logic [DROP_NBITS-1:0]       drop_count
);

  localparam int MSG_NBITS = addr_nbits + nbits;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_in_range;
  logic                  w_port_rdy;
  logic                  w_deliver;
  logic                  w_drop;
  logic [MSG_NBITS-1:0]  w_head;
  logic [addr_nbits-1:0] w_haddr;
  logic [DROP_NBITS-1:0] r_drop_count;

  // Ready depends only on queue occupancy (and reset), never on downstream ready.
  assign istream_rdy = reset & ~w_full;
  assign w_enq       = istream_val & istream_rdy;

  router_queue2 #(
    .width (MSG_NBITS)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_enq   (w_enq),
    .i_deq   (w_deq),
    .i_data  (istream_msg),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_haddr    = addr_nbits'(route_addr(MSG_MAX_NBITS'(w_head), MSG_NBITS, addr_nbits));
  assign w_in_range = int'(w_haddr) < noutputs;

  // Fan the head payload out to every port, raise valid on the addressed one,
  // and pick up that port's ready.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ostream_val = '0;
    w_port_rdy  = 1'b0;
    for (int i = 0; i < noutputs; i++) begin
      ostream_msg[i] = w_head[nbits-1:0];
      if (w_haddr == addr_nbits'(i)) begin
        ostream_val[i] = ~w_empty;
        w_port_rdy     = ostream_rdy[i];
      end
    end
  end

  // In-range heads leave on the port handshake; out-of-range heads leave unconditionally.
  assign w_deliver = ~w_empty & w_in_range & w_port_rdy;
  assign w_drop    = ~w_empty & ~w_in_range;
  assign w_deq     = w_deliver | w_drop;

  // Saturating count of discarded messages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != {DROP_NBITS{1'b1}})) begin
      r_drop_count <= r_drop_count + DROP_NBITS'(1);
    end
  end

  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_addr_router.sv
// Bench for addr_router (nbits=32, noutputs=3): table-driven streaming plus
// hand-written full, head-of-line, reset and saturation sequences, with a
// scoreboard checking every delivered payload.
module tb_addr_router;

  localparam int NB = 32;
  localparam int NO = 3;
  localparam int AB = 2;

  logic          clk;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  logic [AB+NB-1:0] istream_msg;
  logic [NO-1:0] ostream_val;
  logic [NO-1:0] ostream_rdy;
  logic [NB-1:0] ostream_msg [NO];
  logic [15:0]   drop_count;

  addr_router #(.nbits(NB), .noutputs(NO)) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .drop_count  (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          port;
    logic [31:0] pay;
  } sb_item_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] pay;
    logic [2:0]  exp_val;    // ostream_val seen while this row is offered
    logic [31:0] exp_msg;    // payload on the valid port
    logic [15:0] exp_drops;  // drop_count seen while this row is offered
  } vec_t;

  sb_item_t    sb [$];
  vec_t        vecs [7];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] exp_drops = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [31:0] p);
    istream_val = 1'b1;
    istream_msg = {a, p};
  endtask

  // Settle, score this cycle's handshakes, then advance to the next negedge.
  task automatic tick();
    sb_item_t it;
    #1;
    for (int i = 0; i < NO; i++) begin
      if (ostream_val[i] && ostream_rdy[i]) begin
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL sb_unexpected: port %0d delivered %h, want no delivery", i, ostream_msg[i]);
        end else begin
          it = sb.pop_front();
          check("sb_port", 32'(i), 32'(it.port));
          check("sb_payload", ostream_msg[i], it.pay);
        end
      end
    end
    if (istream_val && istream_rdy) begin
      if (int'(istream_msg[AB+NB-1:NB]) < NO) begin
        it.port = int'(istream_msg[AB+NB-1:NB]);
        it.pay  = istream_msg[NB-1:0];
        sb.push_back(it);
      end else if (exp_drops != 16'hFFFF) begin
        exp_drops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'hA000_000A, 3'b000, 32'h0,         16'd0};
    vecs[1] = '{2'd1, 32'hB000_000B, 3'b001, 32'hA000_000A, 16'd0};
    vecs[2] = '{2'd2, 32'hC000_000C, 3'b010, 32'hB000_000B, 16'd0};
    vecs[3] = '{2'd0, 32'hD000_000D, 3'b100, 32'hC000_000C, 16'd0};
    vecs[4] = '{2'd3, 32'h0000_DEAD, 3'b001, 32'hD000_000D, 16'd0};
    vecs[5] = '{2'd1, 32'hE000_000E, 3'b000, 32'h0,         16'd0};
    vecs[6] = '{2'd2, 32'hF000_000F, 3'b010, 32'hE000_000E, 16'd1};

    reset       = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 3'b111;

    // Power-on reset.
    @(negedge clk);
    #1;
    check("rst_rdy", 32'(istream_rdy), 32'd0);
    check("rst_val", 32'(ostream_val), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_rdy", 32'(istream_rdy), 32'd1);

    // Streaming table, all ports ready, one message per cycle (includes a drop).
    for (int k = 0; k < 7; k++) begin
      send(vecs[k].addr, vecs[k].pay);
      #1;
      check("row_rdy", 32'(istream_rdy), 32'd1);
      check("row_val", 32'(ostream_val), 32'(vecs[k].exp_val));
      check("row_drops", 32'(drop_count), 32'(vecs[k].exp_drops));
      for (int i = 0; i < NO; i++)
        if (vecs[k].exp_val[i]) check("row_msg", ostream_msg[i], vecs[k].exp_msg);
      tick();
    end
    istream_val = 1'b0;
    #1;
    check("tail_val", 32'(ostream_val), 32'b100);
    check("tail_msg", ostream_msg[2], 32'hF000_000F);
    check("tail_drops", 32'(drop_count), 32'd1);
    tick();
    check("tail_empty", 32'(ostream_val), 32'd0);

    // Full: port 1 stalled, two addr-1 messages, a third waits at the input.
    ostream_rdy = 3'b101;
    send(2'd1, 32'h1111_0001);
    tick();
    send(2'd1, 32'h1111_0002);
    #1;
    check("full_rdy_b", 32'(istream_rdy), 32'd1);
    tick();
    send(2'd0, 32'h1111_0003);
    #1;
    check("full_rdy_c", 32'(istream_rdy), 32'd0);
    check("full_val_c", 32'(ostream_val), 32'b010);
    check("full_msg_c", ostream_msg[1], 32'h1111_0001);
    tick();
    ostream_rdy = 3'b111;
    #1;
    check("full_nopass", 32'(istream_rdy), 32'd0);
    check("full_hold", ostream_msg[1], 32'h1111_0001);
    tick();
    #1;
    check("full_rdy_back", 32'(istream_rdy), 32'd1);
    check("full_msg_e", ostream_msg[1], 32'h1111_0002);
    tick();
    istream_val = 1'b0;
    #1;
    check("full_val_f", 32'(ostream_val), 32'b001);
    check("full_msg_f", ostream_msg[0], 32'h1111_0003);
    tick();
    check("full_empty", 32'(ostream_val), 32'd0);

    // Head-of-line blocking: addr-2 head stalls the addr-0 message behind it.
    ostream_rdy = 3'b011;
    send(2'd2, 32'h2222_0001);
    tick();
    send(2'd0, 32'h2222_0002);
    tick();
    istream_val = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("hol_val", 32'(ostream_val), 32'b100);
      tick();
    end
    ostream_rdy = 3'b111;
    tick();
    #1;
    check("hol_port0", 32'(ostream_val), 32'b001);
    check("hol_msg0", ostream_msg[0], 32'h2222_0002);
    tick();
    check("hol_empty", 32'(ostream_val), 32'd0);

    // Reset with two entries queued and a nonzero drop count.
    ostream_rdy = 3'b101;
    send(2'd1, 32'h3333_0001);
    tick();
    send(2'd1, 32'h3333_0002);
    tick();
    istream_val = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_val", 32'(ostream_val), 32'd0);
    check("mid_rst_drops", 32'(drop_count), 32'd0);
    check("mid_rst_rdy", 32'(istream_rdy), 32'd0);
    sb.delete();
    exp_drops = 16'd0;
    @(posedge clk);
    #1;
    check("mid_rst_rdy_hold", 32'(istream_rdy), 32'd0);
    @(negedge clk);
    reset       = 1'b1;
    ostream_rdy = 3'b111;
    #1;
    check("mid_rel_rdy", 32'(istream_rdy), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mid_no_stale", 32'(ostream_val), 32'd0);
    end

    // Saturation: 65534 drops reach 0xFFFE, three more stay at 0xFFFF.
    for (int n = 0; n < 65534; n++) begin
      send(2'd3, 32'(n));
      tick();
    end
    istream_val = 1'b0;
    tick();
    tick();
    check("sat_fffe", 32'(drop_count), 32'h0000_FFFE);
    for (int n = 0; n < 3; n++) begin
      send(2'd3, 32'h0000_DEAD);
      tick();
      istream_val = 1'b0;
      tick();
      check("sat_ffff", 32'(drop_count), 32'h0000_FFFF);
    end
    send(2'd0, 32'h4444_0001);
    tick();
    istream_val = 1'b0;
    #1;
    check("sat_after_val", 32'(ostream_val), 32'b001);
    check("sat_after_msg", ostream_msg[0], 32'h4444_0001);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("drops_model", 32'(drop_count), 32'(exp_drops));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
